hazard_unit_md: RTL and testbench

Parametrised successor to the pipeline's forwarding and stall logic for the 5-stage MIPS core, merged into one block. It adds a multi-cycle multiply/divide scoreboard, so HI/LO consumers and back-to-back mult/div ops stall until the unit retires. It also has a saturating stall-cycle performance counter. It sits beside the datapath and drives the F/D enables, the E flush, and all forwarding muxes.

---
 rtl/hazard_unit_md.sv | 121 ++++++++++++
 tb/tb_hazard_unit_md.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_md.sv
// Forwarding, stall and flush control for the 5-stage MIPS pipeline, with a
// multiply/divide busy scoreboard and a saturating stall-cycle counter.
module hazard_unit_md #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             branch_e,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  input  logic             md_use_d,
  input  logic             stall_cnt_clr,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);
  localparam logic [MD_W-1:0]  MUL_LOAD = MD_W'(MUL_LAT);
  localparam logic [MD_W-1:0]  DIV_LOAD = MD_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Register 0 is hardwired, so a producer writing it never creates a dependency.
  function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic [REG_W-1:0] src_e [2];
  logic [REG_W-1:0] src_d [2];
  logic [1:0]       fwd_e [2];
  logic             fwd_d [2];

  assign src_e[0] = rs_e;
  assign src_e[1] = rt_e;
  assign src_d[0] = rs_d;
  assign src_d[1] = rt_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_e[gi] = (reg_write_m && hit(write_reg_m, src_e[gi])) ? 2'b10 :
                       (reg_write_w && hit(write_reg_w, src_e[gi])) ? 2'b01 : 2'b00;
    assign fwd_d[gi] = reg_write_m && hit(write_reg_m, src_d[gi]);
  end

  assign forward_a_e = fwd_e[0];
  assign forward_b_e = fwd_e[1];
  assign forward_a_d = fwd_d[0];
  assign forward_b_d = fwd_d[1];

  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use, branch_alu, branch_load, late_branch_load, md_stall, stall;

  assign load_use         = mem_to_reg_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
  assign branch_alu       = branch_d && reg_write_e &&
                            (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
  assign branch_load      = branch_d && mem_to_reg_m &&
                            (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d));
  assign late_branch_load = branch_e && mem_to_reg_m &&
                            (hit(write_reg_m, rs_e) || hit(write_reg_m, rt_e));
  // An issue in E this cycle must also block a HI/LO consumer sitting in D.
  assign md_stall         = md_use_d && (md_busy || md_start_e);
  assign stall            = load_use || branch_alu || branch_load || late_branch_load || md_stall;

  assign stall_f   = stall;
  assign stall_d   = stall;
  assign flush_e   = stall;
  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e) begin
      md_cnt_d = md_is_div_e ? DIV_LOAD : MUL_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Directed-vector bench for hazard_unit_md; a second instance with a 4-bit
// stall counter exercises saturation on the same stimulus.
module tb_hazard_unit_md;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, branch_e, md_start_e, md_is_div_e, md_use_d, stall_cnt_clr;

  logic [1:0]  forward_a_e, forward_b_e;
  logic        forward_a_d, forward_b_d, stall_f, stall_d, flush_e, md_busy;
  logic [15:0] stall_cnt;

  logic [1:0]  s_forward_a_e, s_forward_b_e;
  logic        s_forward_a_d, s_forward_b_d, s_stall_f, s_stall_d, s_flush_e, s_md_busy;
  logic [3:0]  s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit_md dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .branch_e(branch_e),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d),
    .stall_cnt_clr(stall_cnt_clr),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_unit_md #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .branch_e(branch_e),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d),
    .stall_cnt_clr(stall_cnt_clr),
    .forward_a_e(s_forward_a_e), .forward_b_e(s_forward_b_e),
    .forward_a_d(s_forward_a_d), .forward_b_d(s_forward_b_d),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_e(s_flush_e),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] pass %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; branch_d = 0; branch_e = 0;
    md_start_e = 0; md_is_div_e = 0; md_use_d = 0; stall_cnt_clr = 0;
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] stalls();
    return {stall_f, stall_d, flush_e};
  endfunction

  initial begin
    int n_stall;
    int n_busy;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_md_busy", {31'd0, md_busy}, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("reset_stalls", {29'd0, stalls()}, 32'd0);
    check("reset_fwd", {26'd0, forward_a_e, forward_b_e, forward_a_d, forward_b_d}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Forwarding priority
    rs_e = 5; write_reg_m = 5; reg_write_m = 1; write_reg_w = 5; reg_write_w = 1; #1;
    check("fwd_a_m_priority", {30'd0, forward_a_e}, 32'd2);
    reg_write_m = 0; #1;
    check("fwd_a_from_w", {30'd0, forward_a_e}, 32'd1);
    rs_e = 0; reg_write_m = 1; write_reg_m = 0; write_reg_w = 0; #1;
    check("fwd_a_reg0", {30'd0, forward_a_e}, 32'd0);
    clear_inputs(); rt_e = 9; write_reg_w = 9; reg_write_w = 1; #1;
    check("fwd_b_from_w", {30'd0, forward_b_e}, 32'd1);
    tick();

    // Load-use
    clear_inputs(); mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8; #1;
    check("load_use_stall", {29'd0, stalls()}, 32'd7);
    tick();
    mem_to_reg_e = 0; write_reg_e = 0; mem_to_reg_m = 1; write_reg_m = 8; #1;
    check("load_use_released", {29'd0, stalls()}, 32'd0);
    clear_inputs(); mem_to_reg_e = 1; #1;
    check("load_use_reg0", {29'd0, stalls()}, 32'd0);
    tick();

    // Branch hazards
    clear_inputs(); branch_d = 1; reg_write_e = 1; write_reg_e = 3; rs_d = 3; #1;
    check("branch_alu_stall", {29'd0, stalls()}, 32'd7);
    tick();
    reg_write_e = 0; write_reg_e = 0; write_reg_m = 3; reg_write_m = 1; #1;
    check("branch_alu_next", {29'd0, stalls()}, 32'd0);
    check("branch_fwd_a_d", {31'd0, forward_a_d}, 32'd1);
    clear_inputs(); branch_d = 1; mem_to_reg_m = 1; write_reg_m = 4; rt_d = 4; #1;
    check("branch_load_stall", {29'd0, stalls()}, 32'd7);
    clear_inputs(); branch_e = 1; mem_to_reg_m = 1; write_reg_m = 6; rs_e = 6; #1;
    check("late_branch_load", {29'd0, stalls()}, 32'd7);
    tick();

    // Divide scoreboard: stall t..t+32, busy t+1..t+32
    clear_inputs(); stall_cnt_clr = 1; tick();
    stall_cnt_clr = 0; md_start_e = 1; md_is_div_e = 1; md_use_d = 1; #1;
    n_stall = 0; n_busy = 0;
    check("div_busy_at_t", {31'd0, md_busy}, 32'd0);
    for (int i = 0; i < 40 && stall_d; i++) begin
      n_stall++;
      if (md_busy) n_busy++;
      tick();
      md_start_e = 0; md_is_div_e = 0; #1;
    end
    check("div_stall_cycles", n_stall, 32'd33);
    check("div_busy_cycles", n_busy, 32'd32);
    check("div_busy_after", {31'd0, md_busy}, 32'd0);
    check("div_stall_cnt", {16'd0, stall_cnt}, 32'd33);
    check("div_stall_cnt_sat4", {28'd0, s_stall_cnt}, 32'd15);
    tick();

    // Multiply latency
    clear_inputs(); md_start_e = 1; tick();
    md_start_e = 0; #1;
    n_busy = 0;
    for (int i = 0; i < 10 && md_busy; i++) begin
      n_busy++;
      tick();
    end
    check("mul_busy_cycles", n_busy, 32'd4);

    // Reset mid-divide
    clear_inputs(); md_start_e = 1; md_is_div_e = 1; md_use_d = 1; tick();
    md_start_e = 0; md_is_div_e = 0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_div_busy", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0; #1;
    check("async_rst_busy", {31'd0, md_busy}, 32'd0);
    check("async_rst_stall", {29'd0, stalls()}, 32'd0);
    check("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_md_use", {29'd0, stalls()}, 32'd0);

    // Saturation and clear
    clear_inputs(); mem_to_reg_e = 1; write_reg_e = 7; rs_d = 7;
    for (int i = 0; i < 20; i++) tick();
    check("stall20_cnt", {16'd0, stall_cnt}, 32'd20);
    check("stall20_sat4", {28'd0, s_stall_cnt}, 32'd15);
    stall_cnt_clr = 1; #1;
    check("clr_with_stall_d", {31'd0, stall_d}, 32'd1);
    tick();
    check("clr_wins_cnt", {16'd0, stall_cnt}, 32'd0);
    check("clr_wins_sat4", {28'd0, s_stall_cnt}, 32'd0);
    stall_cnt_clr = 0; tick();
    check("inc_after_clr", {16'd0, stall_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
